// File: rtl/microwave_ctrl.sv
// Microwave oven controller: keypad time entry, BCD countdown, door/start/stop sequencing.
// Optional feature: DONE_AUTOCLEAR_EN returns DONE to IDLE after four 1 Hz ticks.
module microwave_ctrl (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enablen,
  output logic       mag_on,
  output logic       done,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  // state | meaning
  // IDLE  | keypad entry enabled, magnetron off
  // COOK  | magnetron on, display counts down on each tick
  // PAUSE | cooking suspended, time held
  // DONE  | countdown reached 0:00
  typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] min_nxt, tens_nxt, ones_nxt;
  logic       loadn_q, pgt_q, startn_q, stopn_q, primed;
  logic       key, tick, start, stop;
  logic [3:0] dec_min, dec_tens, dec_ones;
  logic       time_zero, dec_zero;

`ifdef DONE_AUTOCLEAR_EN
  logic [1:0] done_cnt, done_cnt_nxt;
`endif

  // primed masks the first edge after reset so inputs held active through release stay quiet
  assign key   = primed & loadn_q  & ~loadn;
  assign tick  = primed & ~pgt_q   & pgt_1hz;
  assign start = primed & startn_q & ~startn;
  assign stop  = primed & stopn_q  & ~stopn;

  assign time_zero = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);

  always_comb begin
    dec_min  = min_ones;
    dec_tens = sec_tens;
    dec_ones = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = sec_tens - 4'd1;
      if (sec_tens == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min_ones - 4'd1;
      end
    end
  end

  assign dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

  always_comb begin
    state_nxt = state;
    min_nxt   = min_ones;
    tens_nxt  = sec_tens;
    ones_nxt  = sec_ones;
`ifdef DONE_AUTOCLEAR_EN
    done_cnt_nxt = done_cnt;
`endif
    case (state)
      IDLE: begin
        if (stop) begin
          min_nxt  = 4'd0;
          tens_nxt = 4'd0;
          ones_nxt = 4'd0;
        end else if (start && door_closed && !time_zero) begin
          state_nxt = COOK;
        end else if (key && (D <= 4'd9)) begin
          min_nxt  = sec_tens;
          tens_nxt = sec_ones;
          ones_nxt = D;
        end
      end
      COOK: begin
        if (stop || !door_closed) begin
          state_nxt = PAUSE;
        end else if (tick) begin
          min_nxt  = dec_min;
          tens_nxt = dec_tens;
          ones_nxt = dec_ones;
          if (dec_zero) begin
            state_nxt = DONE;
`ifdef DONE_AUTOCLEAR_EN
            done_cnt_nxt = 2'd0;
`endif
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
          min_nxt   = 4'd0;
          tens_nxt  = 4'd0;
          ones_nxt  = 4'd0;
        end else if (start && door_closed) begin
          state_nxt = COOK;
        end
      end
      DONE: begin
        if (stop || !door_closed) begin
          state_nxt = IDLE;
          min_nxt   = 4'd0;
          tens_nxt  = 4'd0;
          ones_nxt  = 4'd0;
        end
`ifdef DONE_AUTOCLEAR_EN
        else if (tick) begin
          if (done_cnt == 2'd3) begin
            state_nxt = IDLE;
            min_nxt   = 4'd0;
            tens_nxt  = 4'd0;
            ones_nxt  = 4'd0;
          end else begin
            done_cnt_nxt = done_cnt + 2'd1;
          end
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= IDLE;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      enablen  <= 1'b0;
      mag_on   <= 1'b0;
      done     <= 1'b0;
      loadn_q  <= 1'b1;
      pgt_q    <= 1'b0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      primed   <= 1'b0;
`ifdef DONE_AUTOCLEAR_EN
      done_cnt <= 2'd0;
`endif
    end else begin
      loadn_q  <= loadn;
      pgt_q    <= pgt_1hz;
      startn_q <= startn;
      stopn_q  <= stopn;
      primed   <= 1'b1;
      state    <= state_nxt;
      min_ones <= min_nxt;
      sec_tens <= tens_nxt;
      sec_ones <= ones_nxt;
      enablen  <= (state_nxt != IDLE);
      mag_on   <= (state_nxt == COOK);
      done     <= (state_nxt == DONE);
`ifdef DONE_AUTOCLEAR_EN
      done_cnt <= done_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed vector table plus hand-written corner sequences.
module tb_microwave_ctrl;

  logic       clk = 1'b0;
  logic       clearn;
  logic [3:0] D;
  logic       loadn, pgt_1hz, startn, stopn, door_closed;
  logic       enablen, mag_on, done;
  logic [3:0] min_ones, sec_tens, sec_ones;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int OP_NOP = 0, OP_KEY = 1, OP_START = 2, OP_STOP = 3, OP_TICK = 4, OP_DOOR = 5;

  typedef struct {
    int         op;
    logic [3:0] d;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  microwave_ctrl dut (
    .clk(clk), .clearn(clearn), .D(D), .loadn(loadn), .pgt_1hz(pgt_1hz),
    .startn(startn), .stopn(stopn), .door_closed(door_closed),
    .enablen(enablen), .mag_on(mag_on), .done(done),
    .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones)
  );

  always #5 clk = ~clk;

  // {enablen, mag_on, done, M, S1, S0}
  function automatic logic [14:0] ex(input logic en, input logic mg, input logic dn,
                                     input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    return {en, mg, dn, m, t, o};
  endfunction

  function automatic void add(input int op, input logic [3:0] d, input logic [14:0] e);
    vec_t v;
    v.op = op; v.d = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [14:0] e);
    logic [14:0] act;
    act = {enablen, mag_on, done, min_ones, sec_tens, sec_ones};
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got en=%b mag=%b done=%b %h:%h%h, want en=%b mag=%b done=%b %h:%h%h",
               name, act[14], act[13], act[12], act[11:8], act[7:4], act[3:0],
               e[14], e[13], e[12], e[11:8], e[7:4], e[3:0]);
    end
  endtask

  task automatic apply(input int op, input logic [3:0] d);
    case (op)
      OP_KEY:   begin D = d; loadn = 1'b0; step(); loadn = 1'b1; step(); end
      OP_START: begin startn = 1'b0; step(); startn = 1'b1; step(); end
      OP_STOP:  begin stopn = 1'b0; step(); stopn = 1'b1; step(); end
      OP_TICK:  begin pgt_1hz = 1'b1; step(); pgt_1hz = 1'b0; step(); end
      OP_DOOR:  begin door_closed = d[0]; step(); step(); end
      default:  step();
    endcase
  endtask

  initial begin
    clearn = 1'b0; D = 4'd0; loadn = 1'b1; pgt_1hz = 1'b0;
    startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;

    add(OP_NOP,   0,  ex(0,0,0, 0,0,0));
    add(OP_KEY,   1,  ex(0,0,0, 0,0,1));
    add(OP_KEY,   3,  ex(0,0,0, 0,1,3));
    add(OP_KEY,   0,  ex(0,0,0, 1,3,0));
    add(OP_KEY,   11, ex(0,0,0, 1,3,0));
    add(OP_STOP,  0,  ex(0,0,0, 0,0,0));
    add(OP_START, 0,  ex(0,0,0, 0,0,0));
    add(OP_KEY,   0,  ex(0,0,0, 0,0,0));
    add(OP_KEY,   2,  ex(0,0,0, 0,0,2));
    add(OP_DOOR,  0,  ex(0,0,0, 0,0,2));
    add(OP_START, 0,  ex(0,0,0, 0,0,2));
    add(OP_DOOR,  1,  ex(0,0,0, 0,0,2));
    add(OP_START, 0,  ex(1,1,0, 0,0,2));
    add(OP_TICK,  0,  ex(1,1,0, 0,0,1));
    add(OP_TICK,  0,  ex(1,0,1, 0,0,0));
    add(OP_TICK,  0,  ex(1,0,1, 0,0,0));
    add(OP_STOP,  0,  ex(0,0,0, 0,0,0));
    add(OP_KEY,   1,  ex(0,0,0, 0,0,1));
    add(OP_KEY,   0,  ex(0,0,0, 0,1,0));
    add(OP_KEY,   0,  ex(0,0,0, 1,0,0));
    add(OP_START, 0,  ex(1,1,0, 1,0,0));
    add(OP_TICK,  0,  ex(1,1,0, 0,5,9));
    add(OP_STOP,  0,  ex(1,0,0, 0,5,9));
    add(OP_STOP,  0,  ex(0,0,0, 0,0,0));
    add(OP_KEY,   7,  ex(0,0,0, 0,0,7));
    add(OP_KEY,   0,  ex(0,0,0, 0,7,0));
    add(OP_START, 0,  ex(1,1,0, 0,7,0));
    add(OP_TICK,  0,  ex(1,1,0, 0,6,9));
    add(OP_DOOR,  0,  ex(1,0,0, 0,6,9));
    add(OP_TICK,  0,  ex(1,0,0, 0,6,9));
    add(OP_KEY,   5,  ex(1,0,0, 0,6,9));
    add(OP_DOOR,  1,  ex(1,0,0, 0,6,9));
    add(OP_START, 0,  ex(1,1,0, 0,6,9));
    add(OP_STOP,  0,  ex(1,0,0, 0,6,9));
    add(OP_STOP,  0,  ex(0,0,0, 0,0,0));

    #12;
    check("in_reset", ex(0,0,0, 0,0,0));
    clearn = 1'b1;
    step();

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // door opens on the same edge as a tick: tick is discarded
    apply(OP_KEY, 4); apply(OP_KEY, 5); apply(OP_START, 0);
    check("cook_045", ex(1,1,0, 0,4,5));
    door_closed = 1'b0; pgt_1hz = 1'b1; step();
    check("door_tick_pause", ex(1,0,0, 0,4,5));
    pgt_1hz = 1'b0; door_closed = 1'b1; step();
    apply(OP_START, 0);
    check("resume_045", ex(1,1,0, 0,4,5));
    apply(OP_TICK, 0);
    check("resume_tick", ex(1,1,0, 0,4,4));

    // stop and start together in PAUSE: stop wins
    apply(OP_STOP, 0);
    check("pause_044", ex(1,0,0, 0,4,4));
    stopn = 1'b0; startn = 1'b0; step();
    stopn = 1'b1; startn = 1'b1; step();
    check("stop_start_pause", ex(0,0,0, 0,0,0));

    // async clear mid-COOK, with loadn held low across release
    apply(OP_KEY, 3); apply(OP_KEY, 0); apply(OP_START, 0);
    check("cook_030", ex(1,1,0, 0,3,0));
    D = 4'd5; loadn = 1'b0;
    #3 clearn = 1'b0;
    #1 check("async_clear", ex(0,0,0, 0,0,0));
    step(); step();
    clearn = 1'b1;
    step(); step(); step();
    check("no_spurious_key", ex(0,0,0, 0,0,0));
    loadn = 1'b1; step();
    apply(OP_KEY, 4);
    check("key_after_reset", ex(0,0,0, 0,0,4));

    // DONE behaviour across four ticks
    apply(OP_STOP, 0); apply(OP_KEY, 1); apply(OP_START, 0); apply(OP_TICK, 0);
    check("done_entry", ex(1,0,1, 0,0,0));
    for (int k = 1; k <= 3; k++) begin
      apply(OP_TICK, 0);
      check($sformatf("done_tick%0d", k), ex(1,0,1, 0,0,0));
    end
    apply(OP_TICK, 0);
`ifdef DONE_AUTOCLEAR_EN
    check("autoclear_4th", ex(0,0,0, 0,0,0));
`else
    check("done_persist", ex(1,0,1, 0,0,0));
    apply(OP_DOOR, 0);
    check("done_door_open", ex(0,0,0, 0,0,0));
    apply(OP_DOOR, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
